// File: rtl/decode_stage_pipelined.sv
// decode_stage_pipelined: RV32I/RV64I decode with one valid/ready output register,
// load-use bubble insertion, flush and illegal-instruction reporting.
`default_nettype none

module decode_stage_pipelined #(
  parameter int XLEN = 64,
  parameter bit RV64 = (XLEN == 64)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_pc,
  input  logic [31:0]     i_instruction,
  output logic [4:0]      o_rs1_index,
  output logic [4:0]      o_rs2_index,
  input  logic [XLEN-1:0] i_rs1_value,
  input  logic [XLEN-1:0] i_rs2_value,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_rs1_value,
  output logic [XLEN-1:0] o_rs2_value,
  output logic [XLEN-1:0] o_immediate,
  output logic [31:0]     o_instruction,
  output logic [4:0]      o_rd_index,
  output logic [1:0]      o_alu_op,
  output logic [1:0]      o_alu_a_src,
  output logic            o_alu_src,
  output logic            o_branch,
  output logic            o_jump,
  output logic            o_mem_read,
  output logic            o_mem_write,
  output logic            o_mem_to_reg,
  output logic            o_reg_write,
  output logic            o_word,
  output logic            o_illegal,
  output logic            o_hazard
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;

  logic [6:0]        opcode;
  logic              legal, rs1_used, rs2_used;
  logic              d_reg_write, d_mem_read, d_mem_write, d_mem_to_reg;
  logic              d_branch, d_jump, d_alu_src, d_word;
  logic [1:0]        d_alu_a_src, d_alu_op;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]   imm_ext;
  logic              hazard, upd, accept;

  assign opcode      = i_instruction[6:0];
  assign o_rs1_index = i_instruction[19:15];
  assign o_rs2_index = i_instruction[24:20];

  always_comb begin
    legal        = 1'b0;
    rs1_used     = 1'b1;
    rs2_used     = 1'b0;
    d_reg_write  = 1'b0;
    d_mem_read   = 1'b0;
    d_mem_write  = 1'b0;
    d_mem_to_reg = 1'b0;
    d_branch     = 1'b0;
    d_jump       = 1'b0;
    d_alu_src    = 1'b0;
    d_word       = 1'b0;
    d_alu_a_src  = 2'b00;
    d_alu_op     = 2'b00;
    imm32        = '0;
    // Every listed opcode ends in 2'b11, so compressed encodings fall to default.
    case (opcode)
      OP_R:      begin legal = 1'b1; rs2_used = 1'b1; d_reg_write = 1'b1; d_alu_op = 2'b10; end
      OP_IMM:    begin legal = 1'b1; d_reg_write = 1'b1; d_alu_src = 1'b1; d_alu_op = 2'b11;
                       imm32 = 32'(signed'(i_instruction[31:20])); end
      OP_LOAD:   begin legal = 1'b1; d_reg_write = 1'b1; d_mem_read = 1'b1; d_mem_to_reg = 1'b1;
                       d_alu_src = 1'b1; imm32 = 32'(signed'(i_instruction[31:20])); end
      OP_STORE:  begin legal = 1'b1; rs2_used = 1'b1; d_mem_write = 1'b1; d_alu_src = 1'b1;
                       imm32 = 32'(signed'({i_instruction[31:25], i_instruction[11:7]})); end
      OP_BRANCH: begin legal = 1'b1; rs2_used = 1'b1; d_branch = 1'b1; d_alu_op = 2'b01;
                       imm32 = 32'(signed'({i_instruction[31], i_instruction[7],
                                            i_instruction[30:25], i_instruction[11:8], 1'b0})); end
      OP_JAL:    begin legal = 1'b1; rs1_used = 1'b0; d_reg_write = 1'b1; d_jump = 1'b1;
                       d_alu_src = 1'b1; d_alu_a_src = 2'b01;
                       imm32 = 32'(signed'({i_instruction[31], i_instruction[19:12],
                                            i_instruction[20], i_instruction[30:21], 1'b0})); end
      OP_JALR:   begin legal = 1'b1; d_reg_write = 1'b1; d_jump = 1'b1; d_alu_src = 1'b1;
                       imm32 = 32'(signed'(i_instruction[31:20])); end
      OP_LUI:    begin legal = 1'b1; rs1_used = 1'b0; d_reg_write = 1'b1; d_alu_src = 1'b1;
                       d_alu_a_src = 2'b10; imm32 = {i_instruction[31:12], 12'b0}; end
      OP_AUIPC:  begin legal = 1'b1; rs1_used = 1'b0; d_reg_write = 1'b1; d_alu_src = 1'b1;
                       d_alu_a_src = 2'b01; imm32 = {i_instruction[31:12], 12'b0}; end
      OP_IMM32:  begin legal = RV64; d_reg_write = 1'b1; d_alu_src = 1'b1; d_alu_op = 2'b11;
                       d_word = 1'b1; imm32 = 32'(signed'(i_instruction[31:20])); end
      OP_32:     begin legal = RV64; rs2_used = 1'b1; d_reg_write = 1'b1; d_alu_op = 2'b10;
                       d_word = 1'b1; end
      default:   legal = 1'b0;
    endcase
    if (!legal) begin
      d_reg_write  = 1'b0;
      d_mem_read   = 1'b0;
      d_mem_write  = 1'b0;
      d_mem_to_reg = 1'b0;
      d_branch     = 1'b0;
      d_jump       = 1'b0;
      d_alu_src    = 1'b0;
      d_word       = 1'b0;
      d_alu_a_src  = 2'b00;
      d_alu_op     = 2'b00;
    end
  end

  assign imm_ext = XLEN'(imm32);

  assign hazard = o_valid && o_mem_read && (o_rd_index != 5'd0) &&
                  ((rs1_used && (o_rd_index == o_rs1_index)) ||
                   (rs2_used && (o_rd_index == o_rs2_index)));
  assign o_hazard = hazard;
  assign upd      = !o_valid || i_ready;
  assign o_ready  = i_flush || (i_rst_n && upd && !hazard);
  assign accept   = i_valid && o_ready && !i_flush;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid       <= 1'b0;
      o_pc          <= '0;
      o_rs1_value   <= '0;
      o_rs2_value   <= '0;
      o_immediate   <= '0;
      o_instruction <= '0;
      o_rd_index    <= '0;
      o_alu_op      <= '0;
      o_alu_a_src   <= '0;
      o_alu_src     <= 1'b0;
      o_branch      <= 1'b0;
      o_jump        <= 1'b0;
      o_mem_read    <= 1'b0;
      o_mem_write   <= 1'b0;
      o_mem_to_reg  <= 1'b0;
      o_reg_write   <= 1'b0;
      o_word        <= 1'b0;
      o_illegal     <= 1'b0;
    end else if (i_flush || (upd && !accept)) begin
      // Bubble: controls cleared, data outputs keep their last values.
      o_valid      <= 1'b0;
      o_rd_index   <= '0;
      o_alu_op     <= '0;
      o_alu_a_src  <= '0;
      o_alu_src    <= 1'b0;
      o_branch     <= 1'b0;
      o_jump       <= 1'b0;
      o_mem_read   <= 1'b0;
      o_mem_write  <= 1'b0;
      o_mem_to_reg <= 1'b0;
      o_reg_write  <= 1'b0;
      o_word       <= 1'b0;
      o_illegal    <= 1'b0;
    end else if (upd) begin
      o_valid       <= 1'b1;
      o_pc          <= i_pc;
      o_rs1_value   <= (o_rs1_index == 5'd0) ? '0 : i_rs1_value;
      o_rs2_value   <= (o_rs2_index == 5'd0) ? '0 : i_rs2_value;
      o_immediate   <= imm_ext;
      o_instruction <= i_instruction;
      o_rd_index    <= legal ? i_instruction[11:7] : 5'd0;
      o_alu_op      <= d_alu_op;
      o_alu_a_src   <= d_alu_a_src;
      o_alu_src     <= d_alu_src;
      o_branch      <= d_branch;
      o_jump        <= d_jump;
      o_mem_read    <= d_mem_read;
      o_mem_write   <= d_mem_write;
      o_mem_to_reg  <= d_mem_to_reg;
      o_reg_write   <= d_reg_write;
      o_word        <= d_word;
      o_illegal     <= !legal;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_stage_pipelined.sv
// Directed bench for decode_stage_pipelined: one 64-bit and one 32-bit instance
// share stimulus; each task checks its scenario against hand-computed values.
`default_nettype none

module tb_decode_stage_pipelined;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0, flush = 1'b0, ready = 1'b1;
  logic [63:0] pc = '0, rs1v = '0, rs2v = '0;
  logic [31:0] instr = '0;

  logic        a_ready, a_valid, a_alu_src, a_branch, a_jump, a_mem_read, a_mem_write;
  logic        a_mem_to_reg, a_reg_write, a_word, a_illegal, a_hazard;
  logic [4:0]  a_rs1_idx, a_rs2_idx, a_rd;
  logic [1:0]  a_alu_op, a_alu_a_src;
  logic [63:0] a_pc, a_rs1v, a_rs2v, a_imm;
  logic [31:0] a_instr;

  logic        b_ready, b_valid, b_alu_src, b_branch, b_jump, b_mem_read, b_mem_write;
  logic        b_mem_to_reg, b_reg_write, b_word, b_illegal, b_hazard;
  logic [4:0]  b_rs1_idx, b_rs2_idx, b_rd;
  logic [1:0]  b_alu_op, b_alu_a_src;
  logic [31:0] b_pc, b_rs1v, b_rs2v, b_imm;
  logic [31:0] b_instr;

  int vectors = 0;
  int miscompares = 0;

  localparam logic [31:0] I_BEQ   = 32'hFE000EE3;
  localparam logic [31:0] I_JAL   = 32'h0000006F;
  localparam logic [31:0] I_LUI   = 32'hFFFFF0B7;
  localparam logic [31:0] I_ADDI  = 32'hFFF00093;  // addi x1,x0,-1
  localparam logic [31:0] I_SW    = 32'hFE20AC23;  // sw x2,-8(x1)
  localparam logic [31:0] I_LD5   = 32'h0000B283;  // ld x5,0(x1)
  localparam logic [31:0] I_LD0   = 32'h0000B003;  // ld x0,0(x1)
  localparam logic [31:0] I_ADD   = 32'h00728333;  // add x6,x5,x7
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_ADDIW = 32'h0010809B;  // addiw x1,x1,1

  always #5 clk = ~clk;

  decode_stage_pipelined #(.XLEN(64)) dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(a_ready),
    .i_pc(pc), .i_instruction(instr), .o_rs1_index(a_rs1_idx), .o_rs2_index(a_rs2_idx),
    .i_rs1_value(rs1v), .i_rs2_value(rs2v), .i_flush(flush), .o_valid(a_valid),
    .i_ready(ready), .o_pc(a_pc), .o_rs1_value(a_rs1v), .o_rs2_value(a_rs2v),
    .o_immediate(a_imm), .o_instruction(a_instr), .o_rd_index(a_rd), .o_alu_op(a_alu_op),
    .o_alu_a_src(a_alu_a_src), .o_alu_src(a_alu_src), .o_branch(a_branch), .o_jump(a_jump),
    .o_mem_read(a_mem_read), .o_mem_write(a_mem_write), .o_mem_to_reg(a_mem_to_reg),
    .o_reg_write(a_reg_write), .o_word(a_word), .o_illegal(a_illegal), .o_hazard(a_hazard)
  );

  decode_stage_pipelined #(.XLEN(32)) dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(b_ready),
    .i_pc(pc[31:0]), .i_instruction(instr), .o_rs1_index(b_rs1_idx), .o_rs2_index(b_rs2_idx),
    .i_rs1_value(rs1v[31:0]), .i_rs2_value(rs2v[31:0]), .i_flush(flush), .o_valid(b_valid),
    .i_ready(ready), .o_pc(b_pc), .o_rs1_value(b_rs1v), .o_rs2_value(b_rs2v),
    .o_immediate(b_imm), .o_instruction(b_instr), .o_rd_index(b_rd), .o_alu_op(b_alu_op),
    .o_alu_a_src(b_alu_a_src), .o_alu_src(b_alu_src), .o_branch(b_branch), .o_jump(b_jump),
    .o_mem_read(b_mem_read), .o_mem_write(b_mem_write), .o_mem_to_reg(b_mem_to_reg),
    .o_reg_write(b_reg_write), .o_word(b_word), .o_illegal(b_illegal), .o_hazard(b_hazard)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b0; ready = 1'b1;
    tick();
    vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %0b exp 0", a_valid); end
    vectors++; if (a_pc !== 64'd0) begin miscompares++; $display("FAIL rst_pc got %h exp 0", a_pc); end
    vectors++; if (a_imm !== 64'd0) begin miscompares++; $display("FAIL rst_imm got %h exp 0", a_imm); end
    vectors++; if (a_reg_write !== 1'b0) begin miscompares++; $display("FAIL rst_regwr got %0b exp 0", a_reg_write); end
    vectors++; if (a_ready !== 1'b0) begin miscompares++; $display("FAIL rst_ready_in_reset got %0b exp 0", a_ready); end
    rst_n = 1'b1;
    #1;
    vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready_release got %0b exp 1", a_ready); end
  endtask

  task automatic test_immediates();
    ready = 1'b1; valid = 1'b1; rs1v = 64'h1111; rs2v = 64'h2222;
    pc = 64'h100; instr = I_BEQ;
    tick();
    vectors++; if (a_valid !== 1'b1) begin miscompares++; $display("FAIL beq_valid got %0b exp 1", a_valid); end
    vectors++; if (a_imm !== 64'hFFFFFFFFFFFFFFFC) begin miscompares++; $display("FAIL beq_imm got %h exp -4", a_imm); end
    vectors++; if ({a_branch, a_alu_op, a_alu_src, a_reg_write} !== 5'b1_01_0_0) begin miscompares++;
      $display("FAIL beq_ctrl got %b exp 10100", {a_branch, a_alu_op, a_alu_src, a_reg_write}); end
    vectors++; if (a_pc !== 64'h100) begin miscompares++; $display("FAIL beq_pc got %h exp 100", a_pc); end
    pc = 64'h104; instr = I_JAL;
    tick();
    vectors++; if (a_imm !== 64'd0) begin miscompares++; $display("FAIL jal_imm got %h exp 0", a_imm); end
    vectors++; if ({a_jump, a_reg_write, a_alu_src, a_alu_a_src, a_alu_op} !== 7'b1_1_1_01_00) begin miscompares++;
      $display("FAIL jal_ctrl got %b exp 1110100", {a_jump, a_reg_write, a_alu_src, a_alu_a_src, a_alu_op}); end
    pc = 64'h108; instr = I_LUI;
    tick();
    vectors++; if (a_imm !== 64'hFFFFFFFFFFFFF000) begin miscompares++; $display("FAIL lui_imm64 got %h exp fffffffffffff000", a_imm); end
    vectors++; if (b_imm !== 32'hFFFFF000) begin miscompares++; $display("FAIL lui_imm32 got %h exp fffff000", b_imm); end
    vectors++; if ({a_alu_a_src, a_rd} !== {2'b10, 5'd1}) begin miscompares++;
      $display("FAIL lui_asrc_rd got %b exp 1000001", {a_alu_a_src, a_rd}); end
    pc = 64'h10C; instr = I_ADDI;
    tick();
    vectors++; if (a_imm !== 64'hFFFFFFFFFFFFFFFF) begin miscompares++; $display("FAIL addi_imm got %h exp -1", a_imm); end
    vectors++; if (a_rs1v !== 64'd0) begin miscompares++; $display("FAIL addi_x0_forced got %h exp 0", a_rs1v); end
    vectors++; if (a_rs2v !== 64'h2222) begin miscompares++; $display("FAIL addi_rs2v got %h exp 2222", a_rs2v); end
    vectors++; if (a_alu_op !== 2'b11) begin miscompares++; $display("FAIL addi_aluop got %b exp 11", a_alu_op); end
    pc = 64'h110; instr = I_SW;
    tick();
    vectors++; if (a_imm !== 64'hFFFFFFFFFFFFFFF8) begin miscompares++; $display("FAIL sw_imm got %h exp -8", a_imm); end
    vectors++; if ({a_mem_write, a_reg_write, a_alu_src} !== 3'b101) begin miscompares++;
      $display("FAIL sw_ctrl got %b exp 101", {a_mem_write, a_reg_write, a_alu_src}); end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_load_use();
    ready = 1'b1; valid = 1'b1; pc = 64'h200; instr = I_LD5;
    tick();
    vectors++; if ({a_valid, a_mem_read, a_mem_to_reg, a_rd} !== {3'b111, 5'd5}) begin miscompares++;
      $display("FAIL ld_out got %b exp 11100101", {a_valid, a_mem_read, a_mem_to_reg, a_rd}); end
    pc = 64'h204; instr = I_ADD;
    #1;
    vectors++; if (a_hazard !== 1'b1) begin miscompares++; $display("FAIL lu_hazard got %0b exp 1", a_hazard); end
    vectors++; if (a_ready !== 1'b0) begin miscompares++; $display("FAIL lu_ready got %0b exp 0", a_ready); end
    tick();
    vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL lu_bubble got %0b exp 0", a_valid); end
    vectors++; if (a_hazard !== 1'b0) begin miscompares++; $display("FAIL lu_hazard_clear got %0b exp 0", a_hazard); end
    tick();
    vectors++; if ({a_valid, a_instr} !== {1'b1, I_ADD}) begin miscompares++;
      $display("FAIL lu_add_out got %b/%h exp 1/%h", a_valid, a_instr, I_ADD); end
    vectors++; if ({a_alu_op, a_reg_write, a_rd, a_rs1v} !== {2'b10, 1'b1, 5'd6, 64'h1111}) begin miscompares++;
      $display("FAIL lu_add_ctrl got %b %0b %0d %h", a_alu_op, a_reg_write, a_rd, a_rs1v); end
    pc = 64'h208; instr = I_LD0;
    tick();
    pc = 64'h20C; instr = I_ADD;
    #1;
    vectors++; if ({a_hazard, a_ready} !== 2'b01) begin miscompares++;
      $display("FAIL ld_x0_nohazard got %b exp 01", {a_hazard, a_ready}); end
    tick();
    vectors++; if ({a_valid, a_pc} !== {1'b1, 64'h20C}) begin miscompares++;
      $display("FAIL ld_x0_add_out got %0b/%h exp 1/20c", a_valid, a_pc); end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    ready = 1'b1; valid = 1'b1; pc = 64'h300; instr = I_ADDI;
    tick();
    ready = 1'b0; pc = 64'h304; instr = I_SW;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if ({a_valid, a_pc, a_instr, a_ready} !== {1'b1, 64'h300, I_ADDI, 1'b0}) begin miscompares++;
        $display("FAIL bp_hold_%0d got v%0b pc%h ins%h rdy%0b", i, a_valid, a_pc, a_instr, a_ready); end
      tick();
    end
    ready = 1'b1;
    #1;
    vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %0b exp 1", a_ready); end
    tick();
    vectors++; if ({a_valid, a_pc, a_mem_write} !== {1'b1, 64'h304, 1'b1}) begin miscompares++;
      $display("FAIL bp_next got v%0b pc%h mw%0b exp 1/304/1", a_valid, a_pc, a_mem_write); end
    valid = 1'b0;
    tick();
    vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL bp_nodup got %0b exp 0", a_valid); end
  endtask

  task automatic test_flush();
    ready = 1'b1; valid = 1'b1; pc = 64'h400; instr = I_ADDI;
    tick();
    flush = 1'b1; ready = 1'b0; pc = 64'h404; instr = I_SW;
    #1;
    vectors++; if (a_ready !== 1'b1) begin miscompares++; $display("FAIL fl_ready got %0b exp 1", a_ready); end
    tick();
    vectors++; if ({a_valid, a_reg_write, a_mem_write} !== 3'b000) begin miscompares++;
      $display("FAIL fl_killed got %b exp 000", {a_valid, a_reg_write, a_mem_write}); end
    flush = 1'b0; valid = 1'b0; ready = 1'b1;
    tick();
    vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL fl_dropped got %0b exp 0", a_valid); end
  endtask

  task automatic test_illegal();
    ready = 1'b1; valid = 1'b1; pc = 64'h500; instr = I_BAD;
    tick();
    vectors++; if ({a_valid, a_illegal, a_reg_write, a_alu_src} !== 4'b1100) begin miscompares++;
      $display("FAIL ill_7f got %b exp 1100", {a_valid, a_illegal, a_reg_write, a_alu_src}); end
    pc = 64'h504; instr = I_ADDIW;
    tick();
    vectors++; if ({a_illegal, a_word, a_reg_write, a_alu_op} !== 5'b0_1_1_11) begin miscompares++;
      $display("FAIL addiw64 got %b exp 01111", {a_illegal, a_word, a_reg_write, a_alu_op}); end
    vectors++; if ({b_valid, b_illegal, b_word, b_reg_write} !== 4'b1100) begin miscompares++;
      $display("FAIL addiw32 got %b exp 1100", {b_valid, b_illegal, b_word, b_reg_write}); end
    valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_stall();
    ready = 1'b0; valid = 1'b1; pc = 64'h600; instr = I_LD5;
    ready = 1'b1;
    tick();
    ready = 1'b0; pc = 64'h604; instr = I_ADD;
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if ({a_valid, a_mem_read, a_hazard, a_pc} !== {3'b000, 64'd0}) begin miscompares++;
      $display("FAIL rst_mid got v%0b mr%0b hz%0b pc%h exp all 0", a_valid, a_mem_read, a_hazard, a_pc); end
    tick();
    valid = 1'b0; ready = 1'b1; rst_n = 1'b1;
    tick();
    vectors++; if (a_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_replay got %0b exp 0", a_valid); end
  endtask

  initial begin
    test_reset();
    test_immediates();
    test_load_use();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
